// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control path and ALUControl.
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN adds the HALT state for unknown opcodes.
package multicycle_pkg;

  localparam int unsigned StateW = 4;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  typedef enum logic [StateW-1:0] {
    StReset  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StAddiEx = 4'd11,
    StAddiWb = 4'd12
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , StHalt = 4'd13
`endif
  } state_e;

  localparam logic [1:0] AluBRt      = 2'b00;
  localparam logic [1:0] AluBFour    = 2'b01;
  localparam logic [1:0] AluBSext    = 2'b10;
  localparam logic [1:0] AluBSextSh2 = 2'b11;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       instrDone;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state/opcode decode: control outputs and next state.
// With MULTICYCLE_CTRL_ILLEGAL_TRAP_EN unknown opcodes trap into HALT.
module multicycle_ctrl_decode
  import multicycle_pkg::*;
#(
  parameter int unsigned OP_W = 6
) (
  input  state_e            state,
  input  logic [OP_W-1:0]   opcode,
  input  logic              mem_ready,
  output state_e            state_d,
  output ctrl_t             ctrl
);

  localparam logic [OP_W-1:0] OpRtypeW = OP_W'(OpRtype);
  localparam logic [OP_W-1:0] OpLwW    = OP_W'(OpLw);
  localparam logic [OP_W-1:0] OpSwW    = OP_W'(OpSw);
  localparam logic [OP_W-1:0] OpBeqW   = OP_W'(OpBeq);
  localparam logic [OP_W-1:0] OpJW     = OP_W'(OpJ);
  localparam logic [OP_W-1:0] OpAddiW  = OP_W'(OpAddi);

  always_comb begin
    state_d = state;
    ctrl    = '0;
    unique case (state)
      StReset: state_d = StFetch;
      StFetch: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = AluBFour;
        // IR and PC+4 only latch on the cycle memory actually returns the word
        ctrl.irWrite = mem_ready;
        ctrl.pcWrite = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        ctrl.aluSrcB = AluBSextSh2;
        case (opcode)
          OpLwW, OpSwW: state_d = StMemAdr;
          OpRtypeW:     state_d = StExec;
          OpBeqW:       state_d = StBranch;
          OpJW:         state_d = StJump;
          OpAddiW:      state_d = StAddiEx;
          default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            state_d = StHalt;
`else
            state_d        = StFetch;
            ctrl.instrDone = 1'b1;
`endif
          end
        endcase
      end
      StMemAdr: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = AluBSext;
        state_d      = (opcode == OpSwW) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ctrl.regWrite  = 1'b1;
        ctrl.memToReg  = 1'b1;
        ctrl.instrDone = 1'b1;
        state_d        = StFetch;
      end
      StMemWr: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
        if (mem_ready) begin
          ctrl.instrDone = 1'b1;
          state_d        = StFetch;
        end
      end
      StExec: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = AluBRt;
        ctrl.aluOp   = AluOpFunct;
        state_d      = StAluWb;
      end
      StAluWb: begin
        ctrl.regWrite  = 1'b1;
        ctrl.regDst    = 1'b1;
        ctrl.instrDone = 1'b1;
        state_d        = StFetch;
      end
      StBranch: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = AluBRt;
        ctrl.aluOp       = AluOpSub;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSrc       = PcSrcAluOut;
        ctrl.instrDone   = 1'b1;
        state_d          = StFetch;
      end
      StJump: begin
        ctrl.pcWrite   = 1'b1;
        ctrl.pcSrc     = PcSrcJump;
        ctrl.instrDone = 1'b1;
        state_d        = StFetch;
      end
      StAddiEx: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = AluBSext;
        ctrl.aluOp   = AluOpAdd;
        state_d      = StAddiWb;
      end
      StAddiWb: begin
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
        state_d        = StFetch;
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: async-reset state register around the decode block.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to halt on unknown opcodes.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memToReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic [1:0]         pcSrc,
  output logic               instr_done,
  output logic [STATE_W-1:0] state
);

  state_e              state_q;
  state_e              state_d;
  ctrl_t               ctrl;
  logic [StateW-1:0]   stateBits;

  multicycle_ctrl_decode #(
    .OP_W(OP_W)
  ) u_decode (
    .state    (state_q),
    .opcode   (opcode),
    .mem_ready(mem_ready),
    .state_d  (state_d),
    .ctrl     (ctrl)
  );

  // Outputs decode straight from state_q, so reset clears every strobe immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StReset;
    else      state_q <= state_d;
  end

  assign stateBits   = state_q;
  assign state       = STATE_W'(stateBits);
  assign pcWrite     = ctrl.pcWrite;
  assign pcWriteCond = ctrl.pcWriteCond;
  assign iorD        = ctrl.iorD;
  assign memRead     = ctrl.memRead;
  assign memWrite    = ctrl.memWrite;
  assign irWrite     = ctrl.irWrite;
  assign memToReg    = ctrl.memToReg;
  assign regDst      = ctrl.regDst;
  assign regWrite    = ctrl.regWrite;
  assign aluSrcA     = ctrl.aluSrcA;
  assign aluSrcB     = ctrl.aluSrcB;
  assign aluOp       = ctrl.aluOp;
  assign pcSrc       = ctrl.pcSrc;
  assign instr_done  = ctrl.instrDone;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a shared-memory, multi-cycle variant of the MIPS datapath: one memory port for fetch and data, one ALU reused for PC+4, branch target and execute.
- Sits beside the datapath in the top level.
- Decodes the IR opcode and drives the mux selects and write enables that the single-cycle Control block drives today.
- Adds a memory ready handshake, so fetch and data accesses may stall.

Parameters:
- OP_W, 6, opcode field width (IR[31:26]).
- STATE_W, 4, width of the state register and of the debug state output.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- opcode  in  OP_W  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load if ALU zero (beq)
- iorD  out  1  memory address select: 0=PC, 1=ALUOut
- memRead  out  1  memory read strobe
- memWrite  out  1  memory write strobe
- irWrite  out  1  IR load
- memToReg  out  1  write-back select: 0=ALUOut, 1=MDR
- regDst  out  1  destination select: 0=rt, 1=rd
- regWrite  out  1  register file write
- aluSrcA  out  1  ALU A select: 0=PC, 1=rs
- aluSrcB  out  2  ALU B select: 00=rt, 01=const 4, 10=signext, 11=signext<<2
- aluOp  out  2  to ALUControl: 00=add, 01=sub, 10=funct
- pcSrc  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- state  out  STATE_W  current state, for debug and bench use

Behaviour:
- Opcodes: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000.
- States: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB, HALT (HALT exists only with the option).
- Reset:
  - rst low asynchronously forces state=RESET.
  - In RESET every output is 0, including instr_done and the selects.
  - The first clock after rst rises moves RESET to FETCH.
  - Reset asserted mid-instruction abandons the instruction; no strobe is held.
- Any output not listed for a state is 0 in that state.
- FETCH:
  - memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00.
  - irWrite=pcWrite=mem_ready (Mealy-qualified).
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut). Next state by opcode:
  - LW/SW → MEMADR
  - RTYPE → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDIEX
  - any other opcode → FETCH with instr_done=1 (treated as a NOP).
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEMRD if LW, MEMWR if SW.
- MEMRD: memRead=1, iorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0, instr_done=1. Goes to FETCH.
- MEMWR: memWrite=1, iorD=1. Waits for mem_ready, then goes to FETCH with instr_done=1 in the completing cycle.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Goes to ALUWB.
- ALUWB: regWrite=1, regDst=1, memToReg=0, instr_done=1. Goes to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSrc=01, instr_done=1. Goes to FETCH.
- JUMP: pcWrite=1, pcSrc=10, instr_done=1. Goes to FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0, instr_done=1. Goes to FETCH.
- Handshake:
  - memRead/memWrite stay high and the address select stays stable for every stall cycle.
  - Exactly one strobe is active at a time.
  - mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- Latency in cycles, with zero wait states: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3. Each wait state adds one cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to HALT.
  - HALT drives all outputs 0 and instr_done=0.
  - HALT is exited only by reset.
- Undefined:
  - The HALT state does not exist.
  - An unknown opcode retires as a NOP as described under DECODE.

Decomposition:
- Shared package multicycle_pkg holds:
  - the opcode constants,
  - the state encoding localparams,
  - the aluSrcB, aluOp and pcSrc encodings.
- The ALUControl block also uses the package.
- One sub-module: multicycle_ctrl_decode, combinational (state, opcode, mem_ready) → outputs and next state.
- The top-level module holds only the asynchronous state register.

Test Plan:
- Reset: rst=0 for 3 cycles, then released → all outputs 0 during reset; state=FETCH on the first edge after release; memRead=1 and iorD=0 in FETCH.
- LW 100011 with mem_ready held at 1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regWrite=1 and memToReg=1 in cycle 5; instr_done pulses once.
- SW 101011 with mem_ready low for 3 cycles in MEMWR → memWrite held 4 cycles with iorD=1; then FETCH; instr_done coincides with the mem_ready cycle.
- FETCH stall of 2 cycles → irWrite and pcWrite stay 0 until mem_ready=1, then assert for exactly 1 cycle.
- BEQ 000100 then J 000010 → BRANCH drives aluOp=01, pcWriteCond=1, pcSrc=01; JUMP drives pcWrite=1, pcSrc=10; each takes 3 cycles.
- Opcode 111111, run once with the macro defined and once without → with macro: HALT, with state held until rst=0. Without macro: FETCH on the cycle after DECODE, with instr_done=1.
